// File: rtl/divider_rate_scheduler.sv
// Power-of-two clock divider controller. It owns the divide counter and
// sequences start/stop. Ratio changes are taken over a valid/ready handshake
// and are applied only on a period boundary, so div_out never emits a runt
// phase. All outputs are registered.
`timescale 1ns/1ps

module divider_rate_scheduler #(
   parameter int MAX_N     = 4,
   parameter int DEFAULT_N = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       cfg_valid,
   input  logic [2:0] cfg_n,
   output logic       cfg_ready,
   output logic       cfg_err,
   output logic [2:0] cur_n,
   output logic       div_out,
   output logic       tick,
   output logic       busy
);

   typedef enum logic [1:0] {STOP, RUN, SWITCH} stateT;

   stateT            stateReg;
   logic [MAX_N-1:0] cntReg;
   logic [MAX_N-1:0] cntInc;
   logic [MAX_N-1:0] maskVec;
   logic [MAX_N-1:0] halfVec;
   logic [2:0]       curNReg;
   logic [2:0]       pendNReg;
   logic             divOutReg;
   logic             tickReg;
   logic             cfgErrReg;
   logic             busyReg;
   logic             cfgReadyReg;

   logic             xfer;
   logic             cfgBad;
   logic             cfgGood;
   logic             boundary;
   logic             divBitNext;

   // maskVec has the low cur_n bits set; halfVec selects bit cur_n-1, which
   // becomes div_out. cfg_n is 3 bits wide, so MAX_N never exceeds 7.
   generate
      for (genvar gi = 0; gi < MAX_N; gi++) begin : g_bits
         localparam logic [2:0] IDX = 3'(gi);
         assign maskVec[gi] = (curNReg > IDX);
         assign halfVec[gi] = (curNReg == (IDX + 3'd1));
      end
   endgenerate

   assign cntInc     = cntReg + {{(MAX_N-1){1'b0}}, 1'b1};
   assign divBitNext = |(cntInc & halfVec);
   assign boundary   = ((cntReg & maskVec) == maskVec);
   assign xfer       = cfg_valid && cfgReadyReg;
   assign cfgBad     = (cfg_n == 3'd0) || (cfg_n > 3'(MAX_N));
   assign cfgGood    = xfer && !cfgBad;

   // Scheduler state machine with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg    <= STOP;
         cntReg      <= '0;
         curNReg     <= 3'(DEFAULT_N);
         pendNReg    <= 3'd0;
         divOutReg   <= 1'b0;
         tickReg     <= 1'b0;
         cfgErrReg   <= 1'b0;
         busyReg     <= 1'b0;
         cfgReadyReg <= 1'b1;
      end else begin
         // tick and cfg_err are single-cycle pulses unless reasserted below.
         tickReg   <= 1'b0;
         cfgErrReg <= xfer && cfgBad;
         case (stateReg)
            STOP: begin
               cntReg    <= '0;
               divOutReg <= 1'b0;
               // While stopped there is no period to protect: apply at once.
               if (cfgGood) curNReg <= cfg_n;
               if (run) stateReg <= RUN;
            end
            RUN: begin
               if (!run) begin
                  stateReg  <= STOP;
                  cntReg    <= '0;
                  divOutReg <= 1'b0;
                  if (cfgGood) curNReg <= cfg_n;
               end else begin
                  cntReg    <= cntInc;
                  divOutReg <= divBitNext;
                  tickReg   <= boundary;
                  // The current period still completes; the change waits for
                  // the next boundary.
                  if (cfgGood) begin
                     pendNReg    <= cfg_n;
                     stateReg    <= SWITCH;
                     busyReg     <= 1'b1;
                     cfgReadyReg <= 1'b0;
                  end
               end
            end
            SWITCH: begin
               if (!run) begin
                  // Stop wins over a coincident boundary: no tick, but the
                  // pending ratio is still committed.
                  curNReg     <= pendNReg;
                  cntReg      <= '0;
                  divOutReg   <= 1'b0;
                  busyReg     <= 1'b0;
                  cfgReadyReg <= 1'b1;
                  stateReg    <= STOP;
               end else if (boundary) begin
                  curNReg     <= pendNReg;
                  cntReg      <= '0;
                  divOutReg   <= 1'b0;
                  tickReg     <= 1'b1;
                  busyReg     <= 1'b0;
                  cfgReadyReg <= 1'b1;
                  stateReg    <= RUN;
               end else begin
                  cntReg    <= cntInc;
                  divOutReg <= divBitNext;
               end
            end
            default: begin
               stateReg    <= STOP;
               cntReg      <= '0;
               divOutReg   <= 1'b0;
               busyReg     <= 1'b0;
               cfgReadyReg <= 1'b1;
            end
         endcase
      end
   end

   assign cfg_ready = cfgReadyReg;
   assign cfg_err   = cfgErrReg;
   assign cur_n     = curNReg;
   assign div_out   = divOutReg;
   assign tick      = tickReg;
   assign busy      = busyReg;

endmodule

// File: tb/tb_divider_rate_scheduler.sv
// Directed bench for divider_rate_scheduler: reset, free run, live switch,
// blocking handshake, invalid requests, stop during switch, async reset.
`timescale 1ns/1ps

module tb_divider_rate_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       cfg_valid;
   logic [2:0] cfg_n;
   logic       cfg_ready;
   logic       cfg_err;
   logic [2:0] cur_n;
   logic       div_out;
   logic       tick;
   logic       busy;

   int numChecks = 0;
   int numFails  = 0;
   int ph;

   divider_rate_scheduler #(.MAX_N(4), .DEFAULT_N(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .cfg_valid (cfg_valid),
      .cfg_n     (cfg_n),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .cur_n     (cur_n),
      .div_out   (div_out),
      .tick      (tick),
      .busy      (busy)
   );

   // 20 ns clock
   always #10 clk = ~clk;

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // advance one clock and sample 1 ns after the rising edge
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_n = 3'd0;

      // ---------------- reset ----------------
      #45;
      checkVal("rst_outs", {cur_n, div_out, tick, cfg_ready, busy, cfg_err},
               {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      #10 rst = 1'b1;
      cycle();
      checkVal("rst_idle", {cur_n, div_out, tick, cfg_ready, busy},
               {3'd1, 1'b0, 1'b0, 1'b1, 1'b0});

      // ---------------- free run, N=3 ----------------
      cfg_valid = 1'b1; cfg_n = 3'd3; cycle(); cfg_valid = 1'b0;
      checkVal("stop_cfg", {cur_n, busy, cfg_ready, div_out}, {3'd3, 1'b0, 1'b1, 1'b0});
      run = 1'b1; cycle();
      checkVal("run_entry", {tick, div_out}, {1'b0, 1'b0});
      for (int k = 1; k <= 40; k++) begin
         cycle();
         checkVal($sformatf("free_%0d", k), {cur_n, tick, div_out},
                  {3'd3, (k % 8) == 0, (k % 8) >= 4});
      end
      run = 1'b0; cycle();
      checkVal("stop_clr", {tick, div_out, busy}, {1'b0, 1'b0, 1'b0});

      // ---------------- live switch 4 -> 2 ----------------
      cfg_valid = 1'b1; cfg_n = 3'd4; cycle(); cfg_valid = 1'b0;
      checkVal("stop_cfg4", {13'd0, cur_n}, {13'd0, 3'd4});
      run = 1'b1; cycle();
      for (int k = 1; k <= 5; k++) begin
         cycle();
         checkVal($sformatf("n4_pre_%0d", k), {tick, div_out, busy}, {1'b0, 1'b0, 1'b0});
      end
      cfg_valid = 1'b1; cfg_n = 3'd2; cycle(); cfg_valid = 1'b0;
      checkVal("sw_accept", {busy, cfg_ready, cur_n, div_out}, {1'b1, 1'b0, 3'd4, 1'b0});
      for (int k = 7; k <= 15; k++) begin
         cycle();
         checkVal($sformatf("sw_wait_%0d", k), {busy, cfg_ready, cur_n, tick, div_out},
                  {1'b1, 1'b0, 3'd4, 1'b0, k >= 8});
      end
      cycle();
      checkVal("sw_apply", {busy, cfg_ready, cur_n, tick, div_out},
               {1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
      for (int j = 1; j <= 8; j++) begin
         cycle();
         checkVal($sformatf("n2_run_%0d", j), {cur_n, tick, div_out},
                  {3'd2, (j % 4) == 0, (j % 4) >= 2});
      end

      // ---------------- blocking: 2 -> 3, then held retry -> 1 ----------------
      cfg_valid = 1'b1; cfg_n = 3'd3; cycle();
      checkVal("blk_accept", {busy, cfg_ready, cur_n, tick}, {1'b1, 1'b0, 3'd2, 1'b0});
      cfg_n = 3'd1;
      cycle();
      checkVal("blk_hold_a", {busy, cfg_ready, cur_n, div_out, tick},
               {1'b1, 1'b0, 3'd2, 1'b1, 1'b0});
      cycle();
      checkVal("blk_hold_b", {busy, cfg_ready, cur_n, div_out, tick},
               {1'b1, 1'b0, 3'd2, 1'b1, 1'b0});
      cycle();
      checkVal("blk_apply3", {busy, cfg_ready, cur_n, div_out, tick},
               {1'b0, 1'b1, 3'd3, 1'b0, 1'b1});
      cycle();
      checkVal("blk_retry", {busy, cfg_ready, cur_n, tick}, {1'b1, 1'b0, 3'd3, 1'b0});
      cfg_valid = 1'b0;
      for (int j = 2; j <= 7; j++) begin
         cycle();
         checkVal($sformatf("blk_n3_%0d", j), {busy, cur_n, tick, div_out},
                  {1'b1, 3'd3, 1'b0, j >= 4});
      end
      cycle();
      checkVal("blk_apply1", {busy, cfg_ready, cur_n, tick, div_out},
               {1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
      ph = 0;
      repeat (4) begin
         ph++;
         cycle();
         checkVal("n1_run", {cur_n, tick, div_out}, {3'd1, (ph % 2) == 0, (ph % 2) == 1});
      end

      // ---------------- invalid requests ----------------
      cfg_valid = 1'b1; cfg_n = 3'd0; ph++; cycle(); cfg_valid = 1'b0;
      checkVal("err_zero", {cfg_err, cur_n, busy, cfg_ready, tick, div_out},
               {1'b1, 3'd1, 1'b0, 1'b1, (ph % 2) == 0, (ph % 2) == 1});
      ph++; cycle();
      checkVal("err_zero_end", {cfg_err, cur_n, busy, tick, div_out},
               {1'b0, 3'd1, 1'b0, (ph % 2) == 0, (ph % 2) == 1});
      cfg_valid = 1'b1; cfg_n = 3'd5; ph++; cycle(); cfg_valid = 1'b0;
      checkVal("err_big", {cfg_err, cur_n, busy, cfg_ready, tick, div_out},
               {1'b1, 3'd1, 1'b0, 1'b1, (ph % 2) == 0, (ph % 2) == 1});
      ph++; cycle();
      checkVal("err_big_end", {cfg_err, cur_n, busy, tick, div_out},
               {1'b0, 3'd1, 1'b0, (ph % 2) == 0, (ph % 2) == 1});

      // ---------------- stop during switch (coincides with a boundary) ----------------
      cfg_valid = 1'b1; cfg_n = 3'd2; ph++; cycle(); cfg_valid = 1'b0;
      checkVal("ss_accept", {busy, cfg_ready, cur_n, tick, div_out},
               {1'b1, 1'b0, 3'd1, 1'b0, 1'b1});
      run = 1'b0; cycle();
      checkVal("ss_stop", {busy, cfg_ready, cur_n, tick, div_out},
               {1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
      repeat (2) begin
         cycle();
         checkVal("ss_idle", {busy, cur_n, tick, div_out}, {1'b0, 3'd2, 1'b0, 1'b0});
      end
      run = 1'b1; cycle();
      checkVal("ss_entry", {tick, div_out}, {1'b0, 1'b0});
      for (int j = 1; j <= 4; j++) begin
         cycle();
         checkVal($sformatf("ss_restart_%0d", j), {cur_n, tick, div_out},
                  {3'd2, j == 4, (j % 4) >= 2});
      end

      // ---------------- async reset mid-switch ----------------
      cfg_valid = 1'b1; cfg_n = 3'd4; cycle(); cfg_valid = 1'b0;
      checkVal("ar_accept", {busy, cfg_ready, div_out}, {1'b1, 1'b0, 1'b0});
      cycle();
      checkVal("ar_pre", {busy, div_out, cur_n}, {1'b1, 1'b1, 3'd2});
      #4 rst = 1'b0;
      #2;
      checkVal("ar_outs", {cur_n, div_out, tick, cfg_ready, busy, cfg_err},
               {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      run = 1'b0;
      #4 rst = 1'b1;
      cycle();
      checkVal("ar_idle", {cur_n, busy, div_out, tick}, {3'd1, 1'b0, 1'b0, 1'b0});
      run = 1'b1; cycle();
      for (int j = 1; j <= 4; j++) begin
         cycle();
         checkVal($sformatf("ar_run_%0d", j), {cur_n, busy, tick, div_out},
                  {3'd1, 1'b0, (j % 2) == 0, (j % 2) == 1});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/divider_rate_scheduler.md
Name: divider_rate_scheduler

Overview:
- Run-time controller for the power-of-two clock divider chain: owns the divide counter and sequences start/stop and divide-ratio changes.
- Outputs a square wave at clk/2^N plus a one-cycle tick enable for downstream stopwatch/display logic.
- Accepts ratio-change requests over a valid/ready handshake and applies them only on a period boundary, so div_out never produces a runt pulse.

Parameters:
- MAX_N, 4, largest supported exponent; counter width is MAX_N bits.
- DEFAULT_N, 1, exponent loaded at reset; must satisfy 1 <= DEFAULT_N <= MAX_N.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- run  in  1  level; 1 = divider running, 0 = stopped.
- cfg_valid  in  1  ratio-change request valid.
- cfg_n  in  3  requested exponent N (divide by 2^N).
- cfg_ready  out  1  scheduler can accept a request.
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_n == 0 or cfg_n > MAX_N.
- cur_n  out  3  exponent currently in effect.
- div_out  out  1  divided clock, 50% duty, period 2^cur_n clk cycles.
- tick  out  1  one-cycle pulse per div_out period.
- busy  out  1  1 while a change is pending.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = STOP, cnt = 0, cur_n = DEFAULT_N, pend_n = 0.
  - div_out = 0, tick = 0, cfg_err = 0, busy = 0, cfg_ready = 1.
  - Reset mid-operation discards any pending change.
- All outputs are registered. mask = 2^cur_n - 1. A boundary is the cycle where state is RUN/SWITCH and (cnt & mask) == mask.
- Handshake:
  - A transfer occurs when cfg_valid = 1 and cfg_ready = 1 on a rising edge.
  - cfg_ready = 0 only in SWITCH.
  - cfg_valid held while cfg_ready = 0 must be retried by the requester; nothing is queued beyond one entry.
  - Invalid cfg_n is accepted, raises cfg_err on the next cycle, and changes nothing.
- States:
  - STOP:
    - cnt held at 0; div_out = 0; tick = 0.
    - A valid transfer sets cur_n <= cfg_n on that edge. No pending state is used.
    - run = 1 -> RUN.
  - RUN:
    - Each cycle cnt <= cnt + 1, wrapping modulo 2^MAX_N.
    - div_out <= bit (cur_n-1) of the next cnt.
    - tick <= 1 on the edge after a boundary.
    - A valid transfer sets pend_n <= cfg_n and moves to SWITCH, with busy = 1 from the next cycle.
    - run = 0 -> STOP; cnt and div_out clear on that edge.
  - SWITCH:
    - Counts exactly as in RUN.
    - At a boundary: cur_n <= pend_n, cnt <= 0, div_out <= 0, tick <= 1, busy <= 0, then -> RUN.
    - run = 0 in SWITCH: the change is applied immediately (cur_n <= pend_n), cnt <= 0, -> STOP.
- Simultaneous events:
  - Boundary and run falling in the same cycle: stop takes priority; no tick is issued, and any pending change is applied.
  - Boundary and an accepted request in the same cycle in RUN: the current period completes normally and the request goes pending, taking effect at the next boundary.
  - cfg_n equal to cur_n is a legal no-op change: it still waits for the boundary and realigns cnt to 0.
- Latency:
  - First tick occurs 2^cur_n cycles after the edge entering RUN.
  - After any switch, the new period starts on the boundary edge.

Test Plan:
- Reset: hold rst = 0 for 50 ns at a 20 ns clk -> cur_n = 1, div_out = 0, tick = 0, cfg_ready = 1, busy = 0. Drop rst asynchronously mid-run -> all outputs return to reset values before the next edge.
- Free run: cfg_n = 3 in STOP, then run = 1 for 40 cycles -> div_out period is 8 cycles (4 high, 4 low), tick at cycles 8/16/24/32, cur_n = 3.
- Live switch: in RUN with N = 4, request cfg_n = 2 at cnt = 5 -> cfg_ready drops and busy = 1. The change applies at cnt = 15 (tick), after which the div_out period is 4 cycles. No high or low phase shorter than 2 cycles appears at any point.
- Blocking: during SWITCH, hold cfg_valid with cfg_n = 1 -> no transfer until cfg_ready returns to 1. The retried request is then accepted and takes effect at the following boundary.
- Invalid request: cfg_n = 0, then cfg_n = 5 with MAX_N = 4 -> cfg_err pulses for one cycle each, and cur_n and period are unchanged.
- Stop during switch: run = 0 while in SWITCH with pend_n = 2 -> STOP, cnt = 0, div_out = 0, cur_n = 2, no tick. After run = 1 again, the first tick arrives 4 cycles later.
